fifo_dac_reader: RTL and testbench

- Read-side consumer of the sample FIFO.
- Pops one signed sample per frame while enabled and the FIFO is not empty.
- Shifts each sample out MSB-first on an SPI-style DAC link (cs_n_o, sclk_o, sdata_o).
- Sits between the FIFO read port and the DAC pins, mirroring the function generator on the FIFO write port.

---
 rtl/fifo_defines_pkg.sv | 16 +
 rtl/fifo_dac_reader_sclk_tick_gen.sv | 41 ++++
 rtl/fifo_dac_reader.sv | 198 +++++++++++++++++++
 tb/tb_fifo_dac_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_defines_pkg.sv
// Shared FIFO definitions: sample width, DAC link divider default and the
// read-side FSM encoding used by fifo_dac_reader.
package fifo_defines_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int DAC_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } rd_state_t;

endpackage

// File: rtl/fifo_dac_reader_sclk_tick_gen.sv
// SCLK phase generator: counts CLK_DIV system clocks per SCLK half-period and
// flags the cycle on which SCLK should rise or fall; held cleared while en is low.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;
  logic             wrap_s;

  assign wrap_s    = en && (cnt_r == CNT_LAST);
  assign rise_tick = wrap_s && !phase_r;
  assign fall_tick = wrap_s && phase_r;

  // Half-period counter and current SCLK phase (0 = low half, 1 = high half).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= 1'b0;
    end else if (!en) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/fifo_dac_reader.sv
// Read-side FIFO consumer: pops one sample per frame and shifts it MSB-first to
// an SPI-style DAC. Define FIFO_DAC_OFFSET_BINARY_EN to send offset binary.
module fifo_dac_reader
  import fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
  parameter int CLK_DIV    = fifo_defines_pkg::DAC_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rd_en_o,
  output logic                  cs_n_o,
  output logic                  sclk_o,
  output logic                  sdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  underrun_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int GAP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_PRE  = GAP_W'(CLK_DIV - 2);

  rd_state_t state_r, state_s;

  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] load_word_s;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [GAP_W-1:0]      gap_cnt_r;

  logic rd_en_r, cs_n_r, sclk_r, sdata_r, busy_r, done_r, underrun_r;
  logic rd_en_s, cs_n_s, sclk_s, sdata_s, busy_s, done_s;

  logic tick_en_s, rise_tick_s, fall_tick_s;
  logic start_s, last_fall_s, gap_last_s;

  assign start_s     = en_i && !empty_i;
  assign tick_en_s   = (state_r == SHIFT);
  assign last_fall_s = fall_tick_s && (bit_cnt_r == LAST_BIT);
  assign gap_last_s  = (state_r == GAP) && (gap_cnt_r == GAP_LAST);

`ifdef FIFO_DAC_OFFSET_BINARY_EN
  assign load_word_s = {~data_i[DATA_WIDTH-1], data_i[DATA_WIDTH-2:0]};
`else
  assign load_word_s = data_i;
`endif

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (tick_en_s),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = POP;
        else         state_s = IDLE;
      end
      POP:   state_s = LOAD;
      LOAD:  state_s = SHIFT;
      SHIFT: begin
        if (last_fall_s) state_s = GAP;
        else             state_s = SHIFT;
      end
      GAP: begin
        if (gap_last_s) begin
          if (start_s) state_s = POP;
          else         state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes follow the state being entered.
  always_comb begin
    rd_en_s = (state_s == POP);
    busy_s  = (state_s != IDLE);
    cs_n_s  = (state_s != SHIFT);
    done_s  = (state_r == GAP) && (gap_cnt_r == GAP_PRE);
    sclk_s  = 1'b0;
    sdata_s = 1'b0;
    case (state_r)
      LOAD: begin
        sclk_s  = 1'b0;
        sdata_s = load_word_s[DATA_WIDTH-1];
      end
      SHIFT: begin
        if (rise_tick_s)      sclk_s = 1'b1;
        else if (fall_tick_s) sclk_s = 1'b0;
        else                  sclk_s = sclk_r;
        // The bit after the current MSB sits one below it in the rotating register.
        if (last_fall_s)      sdata_s = 1'b0;
        else if (fall_tick_s) sdata_s = shift_r[DATA_WIDTH-2];
        else                  sdata_s = sdata_r;
      end
      default: begin
        sclk_s  = 1'b0;
        sdata_s = 1'b0;
      end
    endcase
  end

  // Shift register, bit counter and GAP counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      case (state_r)
        LOAD: begin
          shift_r   <= load_word_s;
          bit_cnt_r <= {BIT_W{1'b0}};
        end
        SHIFT: begin
          if (fall_tick_s) begin
            shift_r   <= {shift_r[DATA_WIDTH-2:0], shift_r[DATA_WIDTH-1]};
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
          end
        end
        default: begin
          shift_r   <= shift_r;
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
      if ((state_r == GAP) && !gap_last_s) gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      else                                 gap_cnt_r <= {GAP_W{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_r <= 1'b0;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      rd_en_r <= rd_en_s;
      cs_n_r  <= cs_n_s;
      sclk_r  <= sclk_s;
      sdata_r <= sdata_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Sticky starvation flag: a frame ended while streaming but nothing was queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_r <= 1'b0;
    end else if (!en_i) begin
      underrun_r <= 1'b0;
    end else if (gap_last_s && empty_i) begin
      underrun_r <= 1'b1;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign rd_en_o    = rd_en_r;
  assign cs_n_o     = cs_n_r;
  assign sclk_o     = sclk_r;
  assign sdata_o    = sdata_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign underrun_o = underrun_r;

endmodule

// File: tb/tb_fifo_dac_reader.sv
// Bench for fifo_dac_reader: queue FIFO model, DAC-side bit monitor and a
// frame-level reference (word order, frame period, offset-binary option).
`timescale 1ns/1ps
module tb_fifo_dac_reader;

  localparam int DW           = 16;
  localparam int CD           = 4;
  localparam int FRAME_PERIOD = 2 + 2*CD*DW + CD;
  localparam int CS_LOW_LEN   = 2*CD*DW;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          en_i    = 1'b0;
  logic          empty_i = 1'b1;
  logic [DW-1:0] data_i  = 16'h0000;
  logic rd_en_o, cs_n_o, sclk_o, sdata_o, busy_o, done_o, underrun_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [DW-1:0] fifo_q[$];
  logic          hold_data = 1'b0;

  int pops = 0, rd_double = 0, rd_on_empty = 0, done_cnt = 0;
  int done_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, cs_len = 0, mon_bits = 0;
  logic [DW-1:0] mon_word = 16'h0000;
  logic [DW-1:0] rx_q[$];
  int            rx_bits[$];
  int            pop_cyc[$];
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_rd = 1'b0;

  fifo_dac_reader #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .empty_i(empty_i), .data_i(data_i),
    .rd_en_o(rd_en_o), .cs_n_o(cs_n_o), .sclk_o(sclk_o), .sdata_o(sdata_o),
    .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // What the DAC should receive for a given FIFO sample.
  function automatic logic [DW-1:0] dac_code(input logic [DW-1:0] s);
`ifdef FIFO_DAC_OFFSET_BINARY_EN
    return DW'(int'(s) + (1 << (DW-1)));
`else
    return s;
`endif
  endfunction

  // FIFO model (data valid the cycle after a pop, junk otherwise) and DAC-side monitor.
  always @(negedge clk) begin
    if (rd_en_o) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (prev_rd) rd_double++;
      if (fifo_q.size() == 0) rd_on_empty++;
      else data_i = fifo_q.pop_front();
      hold_data = 1'b1;
    end else if (hold_data) begin
      hold_data = 1'b0;
    end else begin
      data_i = DW'($urandom);
    end
    empty_i = (fifo_q.size() == 0);
    prev_rd = rd_en_o;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (!cs_n_o && prev_cs) begin cs_fall_cyc = cyc; mon_bits = 0; mon_word = 16'h0000; end
    if (!cs_n_o && sclk_o && !prev_sclk) begin
      mon_word = {mon_word[DW-2:0], sdata_o};
      mon_bits++;
    end
    if (cs_n_o && !prev_cs) begin
      rx_q.push_back(mon_word);
      rx_bits.push_back(mon_bits);
      cs_rise_cyc = cyc;
      cs_len = cyc - cs_fall_cyc;
    end
    prev_cs = cs_n_o;
    prev_sclk = sclk_o;
  end

  task clear_mon;
    @(negedge clk); #1;
    pops = 0; done_cnt = 0; mon_bits = 0;
    rx_q.delete(); rx_bits.delete(); pop_cyc.delete();
  endtask

  task wait_done(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin @(negedge clk); #1; i++; end
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++;
      $display("FAIL %s: timeout, done pulses %0d, required %0d", tag, done_cnt, target);
    end
  endtask

  task test_reset;
    logic [DW-1:0] w;
    w = DW'($urandom);
    rst = 1'b0; en_i = 1'b1;
    fifo_q.push_back(w);
    repeat (5) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({rd_en_o, cs_n_o, sclk_o, sdata_o, busy_o, done_o, underrun_o} !== 7'b0100000) begin
        n_bad++;
        $display("FAIL reset_values: got %b required 0100000",
                 {rd_en_o, cs_n_o, sclk_o, sdata_o, busy_o, done_o, underrun_o});
      end
    end
    n_cmp++;
    if (pops != 0) begin n_bad++; $display("FAIL reset_no_pop: got %0d pops required 0", pops); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (rd_en_o !== 1'b1) begin n_bad++; $display("FAIL release_pop: rd_en_o %b required 1", rd_en_o); end
    @(negedge clk); #1;
    n_cmp++;
    if (rd_en_o !== 1'b0) begin n_bad++; $display("FAIL pop_width: rd_en_o %b required 0", rd_en_o); end
    wait_done(1, 300, "reset_frame_done");
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== dac_code(w)) begin
      n_bad++;
      $display("FAIL reset_frame: got %0d words, first %h, required %h", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 16'h0000, dac_code(w));
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task test_single_frame;
    logic [DW-1:0] w;
    w = 16'hA5C3;
    clear_mon;
    en_i = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (underrun_o !== 1'b0 || busy_o !== 1'b0 || pops != 0) begin
      n_bad++;
      $display("FAIL idle_empty: underrun %b busy %b pops %0d required 0 0 0", underrun_o, busy_o, pops);
    end
    fifo_q.push_back(w);
    wait_done(1, 400, "single_done");
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (pops != 1) begin n_bad++; $display("FAIL single_pops: got %0d required 1", pops); end
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== dac_code(w) || rx_bits[0] != DW) begin
      n_bad++;
      $display("FAIL single_word: got %0d words first %h required %h with %0d bits", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 16'h0000, dac_code(w), DW);
    end
    n_cmp++;
    if (cs_len != CS_LOW_LEN) begin n_bad++; $display("FAIL cs_low_len: got %0d required %0d", cs_len, CS_LOW_LEN); end
    // done lands on the CD-th cycle of chip-select high
    n_cmp++;
    if (done_cyc - cs_rise_cyc != CD - 1) begin
      n_bad++;
      $display("FAIL done_offset: got %0d required %0d", done_cyc - cs_rise_cyc, CD - 1);
    end
    n_cmp++;
    if (done_cnt != 1 || underrun_o !== 1'b1) begin
      n_bad++;
      $display("FAIL single_end: done %0d underrun %b required 1 1", done_cnt, underrun_o);
    end
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (underrun_o !== 1'b0) begin n_bad++; $display("FAIL underrun_clear: got %b required 0", underrun_o); end
  endtask

  task test_back_to_back;
    logic [DW-1:0] words[3];
    int busy_drop, i;
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'h7FFF;
    clear_mon;
    for (int k = 0; k < 3; k++) fifo_q.push_back(words[k]);
    repeat (2) @(negedge clk);
    #1;
    en_i = 1'b1;
    busy_drop = 0; i = 0;
    while (done_cnt < 3 && i < 3*FRAME_PERIOD + 50) begin
      @(negedge clk); #1; i++;
      if (pops > 0 && busy_o !== 1'b1) busy_drop++;
    end
    n_cmp++;
    if (done_cnt < 3) begin n_bad++; $display("FAIL b2b_timeout: done %0d required 3", done_cnt); end
    n_cmp++;
    if (busy_drop != 0) begin n_bad++; $display("FAIL b2b_busy: low for %0d cycles required 0", busy_drop); end
    for (int k = 1; k < 3; k++) begin
      n_cmp++;
      if (pop_cyc.size() != 3 || pop_cyc[k] - pop_cyc[k-1] != FRAME_PERIOD) begin
        n_bad++;
        $display("FAIL b2b_period%0d: %0d pops, spacing %0d required %0d", k, pop_cyc.size(),
                 (pop_cyc.size() > k) ? pop_cyc[k] - pop_cyc[k-1] : -1, FRAME_PERIOD);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rx_q.size() != 3 || rx_q[k] !== dac_code(words[k])) begin
        n_bad++;
        $display("FAIL b2b_word%0d: %0d words, got %h required %h", k, rx_q.size(),
                 (rx_q.size() > k) ? rx_q[k] : 16'h0000, dac_code(words[k]));
      end
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (underrun_o !== 1'b1) begin n_bad++; $display("FAIL b2b_underrun: got %b required 1", underrun_o); end
    en_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task test_disable_mid_frame;
    int i;
    clear_mon;
    fifo_q.push_back(16'hFFFF);
    fifo_q.push_back(DW'($urandom));
    repeat (2) @(negedge clk);
    #1;
    en_i = 1'b1;
    i = 0;
    while (!(mon_bits >= 5 && !cs_n_o) && i < 300) begin @(negedge clk); #1; i++; end
    en_i = 1'b0;
    wait_done(1, 300, "disable_done");
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== dac_code(16'hFFFF) || rx_bits[0] != DW) begin
      n_bad++;
      $display("FAIL disable_word: %0d words, got %h required %h", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 16'h0000, dac_code(16'hFFFF));
    end
    n_cmp++;
    if (pops != 1 || fifo_q.size() != 1) begin
      n_bad++;
      $display("FAIL disable_pops: pops %0d left %0d required 1 1", pops, fifo_q.size());
    end
    n_cmp++;
    if (busy_o !== 1'b0 || underrun_o !== 1'b0 || cs_n_o !== 1'b1) begin
      n_bad++;
      $display("FAIL disable_idle: busy %b underrun %b cs_n %b required 0 0 1", busy_o, underrun_o, cs_n_o);
    end
    fifo_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task test_reset_mid_shift;
    logic [DW-1:0] w1, w2;
    int i;
    w1 = DW'($urandom); w2 = DW'($urandom);
    clear_mon;
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    repeat (2) @(negedge clk);
    #1;
    en_i = 1'b1;
    i = 0;
    while (!(mon_bits >= 8 && !cs_n_o) && i < 300) begin @(negedge clk); #1; i++; end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (cs_n_o !== 1'b1 || sclk_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_now: cs_n %b sclk %b busy %b required 1 0 0", cs_n_o, sclk_o, busy_o);
    end
    clear_mon;
    rst = 1'b1;
    wait_done(1, 400, "after_abort_done");
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== dac_code(w2) || rx_bits[0] != DW || pops != 1) begin
      n_bad++;
      $display("FAIL after_abort: %0d words pops %0d, got %h required %h", rx_q.size(), pops,
               (rx_q.size() > 0) ? rx_q[0] : 16'h0000, dac_code(w2));
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task test_offset_binary;
    logic [DW-1:0] want;
`ifdef FIFO_DAC_OFFSET_BINARY_EN
    want = 16'h0000;
`else
    want = 16'h8000;
`endif
    clear_mon;
    fifo_q.push_back(16'h8000);
    en_i = 1'b1;
    wait_done(1, 400, "offset_done");
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== want) begin
      n_bad++;
      $display("FAIL offset_code: got %h required %h", (rx_q.size() > 0) ? rx_q[0] : 16'h0000, want);
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task test_random_streams;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int n;
    for (int it = 0; it < 3; it++) begin
      clear_mon;
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        w = DW'($urandom);
        fifo_q.push_back(w);
        exp_q.push_back(dac_code(w));
      end
      repeat (2) @(negedge clk);
      #1;
      en_i = 1'b1;
      wait_done(n, n*FRAME_PERIOD + 50, "rand_done");
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (rx_q.size() != n || underrun_o !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_count: %0d words underrun %b required %0d 1", rx_q.size(), underrun_o, n);
      end
      for (int k = 0; k < n && k < rx_q.size(); k++) begin
        n_cmp++;
        if (rx_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL rand_word%0d: got %h required %h", k, rx_q[k], exp_q[k]); end
      end
      for (int k = 1; k < pop_cyc.size(); k++) begin
        n_cmp++;
        if (pop_cyc[k] - pop_cyc[k-1] != FRAME_PERIOD) begin
          n_bad++;
          $display("FAIL rand_period: got %0d required %0d", pop_cyc[k] - pop_cyc[k-1], FRAME_PERIOD);
        end
      end
      en_i = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_disable_mid_frame();
    test_reset_mid_shift();
    test_offset_binary();
    test_random_streams();
    n_cmp++;
    if (rd_double != 0 || rd_on_empty != 0) begin
      n_bad++;
      $display("FAIL pop_strobe: multi-cycle %0d on-empty %0d required 0 0", rd_double, rd_on_empty);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
